bpu_upd_sched: RTL and testbench
================================

// Module: bpu_upd_sched
// PURPOSE
// - Commit-side update scheduler for the micro branch predictor (uBTB, uPHT, GHR, SatCnt FIFO).
// - Buffers resolved-branch commit records and arbitrates predictor-update slots against front-end lookups.
// - Issues each update as one-cycle pulses: ubtb/upht/ghr/satCnt update, last_jump, jumpsrc/jumpdst.
// - Sits between the commit stage and the uPredictor update inputs.
// PARAMETERS
// - MXLEN       32  PC / target width.
// - DEPTH       4   Commit-record queue depth, power of 2, >=2.
// - UPD_GAP     1   Idle cycles forced after each issue (0 = back-to-back issue allowed).
// - STARVE_MAX  7   Consecutive lost arbitrations before an update is forced.
// PORTS
// - i_clk          in   1               Clock.
// - i_rstn         in   1               Reset: asynchronous, active-low.
// - i_flush        in   1               Pipeline flush; drops all queued, unissued records.
// - i_cmt_valid    in   1               Commit record valid.
// - o_cmt_ready    out  1               Queue can accept a record (= count < DEPTH).
// - i_cmt_pc       in   MXLEN           PC of the resolved branch.
// - i_cmt_target   in   MXLEN           Resolved target.
// - i_cmt_taken    in   1               Branch resolved taken.
// - i_cmt_is_cond  in   1               Conditional branch; 0 = unconditional jump.
// - i_lookup_vld   in   1               Front-end predictor lookup this cycle (uPredictor pc_valid).
// - o_lookup_stall out  1               Front end must hold its lookup this cycle (forced update).
// - o_ubtb_update  out  1               Pulse: write uBTB.
// - o_upht_update  out  1               Pulse: write uPHT.
// - o_ghr_update   out  1               Pulse: shift GHR.
// - o_satCnt_update out 1               Pulse: pop SatCnt FIFO.
// - o_last_jump    out  1               Taken bit for GHR shift / counter commit.
// - o_pc_jumpsrc   out  MXLEN           Branch PC for the update.
// - o_pc_jumpdst   out  MXLEN           Branch target for the update.
// - o_q_count      out  $clog2(DEPTH)+1 Queue occupancy.
// BEHAVIOUR
// - Reset: queue empty, FSM IDLE, starve count 0; all outputs 0 except o_cmt_ready = 1.
// - Enqueue: i_cmt_valid && o_cmt_ready, on the clock edge. o_cmt_ready depends only on registered count.
// - When full, no enqueue even if a pop occurs in the same cycle.
// - Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
// - FSM states: IDLE, GAP.
// - IDLE + non-empty: grant when !i_lookup_vld, or when starve count == STARVE_MAX.
// - IDLE + non-empty + i_lookup_vld + starve count < STARVE_MAX: starve count +1.
// - Forced grant: o_lookup_stall = 1, combinational, in the same cycle.
// - Grant at cycle N: pop the head and clear starve count.
// - Registered outputs at N+1, valid for exactly one cycle:
//   - o_ubtb_update = taken.
//   - o_upht_update = o_ghr_update = o_satCnt_update = is_cond.
//   - o_last_jump = taken.
//   - o_pc_jumpsrc = pc, o_pc_jumpdst = target.
// - Data outputs hold their last value when no pulse is active.
// - Not-taken unconditional record: popped with all pulses 0 (dropped).
// - After a grant: UPD_GAP > 0 -> GAP for UPD_GAP cycles, then IDLE; UPD_GAP == 0 -> stay IDLE, next grant at N+1.
// - Starve count never increments in GAP or while empty.
// - Flush has priority over everything in its cycle:
//   - Queue emptied, a push in the same cycle dropped, FSM -> IDLE, starve count 0.
//   - A grant in the flush cycle is cancelled: no pulses at N+1.
//   - A pulse already registered from the previous cycle still completes.
// - Async reset mid-operation: everything returns to reset values immediately.
// - Assertions:
//   - No pulse without a preceding grant.
//   - o_q_count <= DEPTH.
//   - o_lookup_stall -> grant in the same cycle.
// TESTING
// - Push 1 cond taken (pc=0x100, tgt=0x200), lookup idle:
//   - all four pulses 1 cycle after grant, last_jump = 1, jumpsrc = 0x100.
// - Push 5 back-to-back, DEPTH = 4, lookup idle:
//   - o_cmt_ready drops after 4 pushes; records issue in order, spaced UPD_GAP + 1 cycles.
// - i_lookup_vld held high with 1 record queued:
//   - o_lookup_stall and grant on the 8th cycle (STARVE_MAX = 7); pulse on the 9th.
// - Uncond jump (is_cond = 0, taken = 1): only o_ubtb_update pulses.
// - Cond not-taken: upht/ghr/satCnt pulse, ubtb 0, last_jump 0.
// - i_flush asserted with 3 queued and a grant pending:
//   - no pulse next cycle, o_q_count = 0 next cycle, concurrent push dropped.

Source files
------------

// File: rtl/bpu_upd_sched.sv
// Commit-side update scheduler for the micro branch predictor.
// Queues resolved-branch records and issues one-cycle predictor-update pulses
// into slots not used by front-end lookups, forcing a slot after prolonged starvation.
module bpu_upd_sched #(
  parameter int unsigned MXLEN      = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned UPD_GAP    = 1,
  parameter int unsigned STARVE_MAX = 7
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_flush,
  input  logic                     i_cmt_valid,
  output logic                     o_cmt_ready,
  input  logic [MXLEN-1:0]         i_cmt_pc,
  input  logic [MXLEN-1:0]         i_cmt_target,
  input  logic                     i_cmt_taken,
  input  logic                     i_cmt_is_cond,
  input  logic                     i_lookup_vld,
  output logic                     o_lookup_stall,
  output logic                     o_ubtb_update,
  output logic                     o_upht_update,
  output logic                     o_ghr_update,
  output logic                     o_satCnt_update,
  output logic                     o_last_jump,
  output logic [MXLEN-1:0]         o_pc_jumpsrc,
  output logic [MXLEN-1:0]         o_pc_jumpdst,
  output logic [$clog2(DEPTH):0]   o_q_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int unsigned GW = (UPD_GAP < 2) ? 1 : $clog2(UPD_GAP);

  typedef enum logic {IDLE, GAP} state_t;

  state_t          state;
  logic [GW-1:0]   gap;
  logic [SW-1:0]   starve;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic [MXLEN-1:0] pc_mem  [DEPTH];
  logic [MXLEN-1:0] tgt_mem [DEPTH];
  logic [DEPTH-1:0] taken_mem;
  logic [DEPTH-1:0] cond_mem;

  logic empty;
  logic starved;
  logic grant;
  logic push;
  logic hd_taken;
  logic hd_cond;

  // Arbitration: flush cancels any grant; a lookup only loses its slot when starvation is maxed
  always_comb begin
    empty          = (count == '0);
    o_cmt_ready    = (count < CW'(DEPTH));
    starved        = (starve == SW'(STARVE_MAX));
    grant          = !i_flush && (state == IDLE) && !empty && (!i_lookup_vld || starved);
    o_lookup_stall = grant && i_lookup_vld;
    push           = i_cmt_valid && o_cmt_ready && !i_flush;
    hd_taken       = taken_mem[rd_ptr];
    hd_cond        = cond_mem[rd_ptr];
    o_q_count      = count;
  end

  // Record storage; contents are don't-care until written, so no reset
  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= i_cmt_pc;
      tgt_mem[wr_ptr]   <= i_cmt_target;
      taken_mem[wr_ptr] <= i_cmt_taken;
      cond_mem[wr_ptr]  <= i_cmt_is_cond;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (grant) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(grant);
    end
  end

  // Issue FSM: post-issue gap and starvation counting
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= IDLE;
      gap    <= '0;
      starve <= '0;
    end else if (i_flush) begin
      state  <= IDLE;
      gap    <= '0;
      starve <= '0;
    end else if (grant) begin
      starve <= '0;
      if (UPD_GAP > 0) begin
        state <= GAP;
        gap   <= GW'(UPD_GAP - 1);
      end
    end else if (state == GAP) begin
      if (gap == '0) state <= IDLE;
      else           gap   <= gap - GW'(1);
    end else if (!empty && i_lookup_vld && !starved) begin
      starve <= starve + SW'(1);
    end
  end

  // Registered update pulses; data outputs only move when some pulse fires
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_ubtb_update   <= 1'b0;
      o_upht_update   <= 1'b0;
      o_ghr_update    <= 1'b0;
      o_satCnt_update <= 1'b0;
      o_last_jump     <= 1'b0;
      o_pc_jumpsrc    <= '0;
      o_pc_jumpdst    <= '0;
    end else begin
      o_ubtb_update   <= grant && hd_taken;
      o_upht_update   <= grant && hd_cond;
      o_ghr_update    <= grant && hd_cond;
      o_satCnt_update <= grant && hd_cond;
      o_last_jump     <= grant && hd_taken;
      if (grant && (hd_taken || hd_cond)) begin
        o_pc_jumpsrc <= pc_mem[rd_ptr];
        o_pc_jumpdst <= tgt_mem[rd_ptr];
      end
    end
  end

  a_pulse_has_grant: assert property (@(posedge i_clk) disable iff (!i_rstn)
    (o_ubtb_update || o_upht_update || o_ghr_update || o_satCnt_update) |-> $past(grant));
  a_count_bound: assert property (@(posedge i_clk) disable iff (!i_rstn)
    o_q_count <= CW'(DEPTH));
  a_stall_grant: assert property (@(posedge i_clk) disable iff (!i_rstn)
    o_lookup_stall |-> grant);

endmodule

// File: tb/tb_bpu_upd_sched.sv
// Scoreboard bench for bpu_upd_sched: stimulus pushes expected updates,
// a negedge monitor pops and compares whenever any update pulse is seen.
module tb_bpu_upd_sched;
  localparam int MXLEN = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  logic cmt_valid = 1'b0;
  logic taken = 1'b0;
  logic is_cond = 1'b0;
  logic lookup = 1'b0;
  logic [MXLEN-1:0] pc = '0;
  logic [MXLEN-1:0] tgt = '0;

  logic cmt_ready, lookup_stall, ubtb, upht, ghr, satcnt, last_jump;
  logic [MXLEN-1:0] jumpsrc, jumpdst;
  logic [$clog2(DEPTH):0] q_count;

  bpu_upd_sched #(.MXLEN(MXLEN), .DEPTH(DEPTH), .UPD_GAP(1), .STARVE_MAX(7)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_flush(flush),
    .i_cmt_valid(cmt_valid), .o_cmt_ready(cmt_ready),
    .i_cmt_pc(pc), .i_cmt_target(tgt), .i_cmt_taken(taken), .i_cmt_is_cond(is_cond),
    .i_lookup_vld(lookup), .o_lookup_stall(lookup_stall),
    .o_ubtb_update(ubtb), .o_upht_update(upht), .o_ghr_update(ghr),
    .o_satCnt_update(satcnt), .o_last_jump(last_jump),
    .o_pc_jumpsrc(jumpsrc), .o_pc_jumpdst(jumpdst), .o_q_count(q_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic             ubtb;
    logic             cond;
    logic             lj;
    logic [MXLEN-1:0] src;
    logic [MXLEN-1:0] dst;
  } upd_t;

  upd_t exp_q[$];
  int   exp_cyc[$];
  upd_t e_upd;
  int   e_at;
  int   checks = 0;
  int   errors = 0;
  int   c;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Record an expected issue; t/cnd are the record's taken/is_cond bits
  task automatic expect_upd(input logic t, input logic cnd, input logic [MXLEN-1:0] p,
                            input logic [MXLEN-1:0] d, input int at);
    upd_t u;
    u.ubtb = t;
    u.cond = cnd;
    u.lj   = t;
    u.src  = p;
    u.dst  = d;
    exp_q.push_back(u);
    exp_cyc.push_back(at);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [MXLEN-1:0] p, input logic [MXLEN-1:0] d,
                      input logic t, input logic cnd);
    pc = p; tgt = d; taken = t; is_cond = cnd; cmt_valid = 1'b1;
    tick();
    cmt_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q_count != 0 || exp_q.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_in_time", 64'(n < 100), 64'd1);
    repeat (3) tick();
  endtask

  // Monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rstn && (ubtb || upht || ghr || satcnt)) begin
      chk("pulse_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e_upd = exp_q.pop_front();
        e_at  = exp_cyc.pop_front();
        chk("ubtb_update", 64'(ubtb), 64'(e_upd.ubtb));
        chk("upht_update", 64'(upht), 64'(e_upd.cond));
        chk("ghr_update", 64'(ghr), 64'(e_upd.cond));
        chk("satcnt_update", 64'(satcnt), 64'(e_upd.cond));
        chk("last_jump", 64'(last_jump), 64'(e_upd.lj));
        chk("jumpsrc", 64'(jumpsrc), 64'(e_upd.src));
        chk("jumpdst", 64'(jumpdst), 64'(e_upd.dst));
        chk("issue_cycle", 64'(cyc), 64'(e_at));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(cmt_ready), 64'd1);
    chk("rst_count", 64'(q_count), 64'd0);
    chk("rst_pulses", 64'({ubtb, upht, ghr, satcnt, last_jump}), 64'd0);
    chk("rst_stall", 64'(lookup_stall), 64'd0);
    chk("rst_jumpsrc", 64'(jumpsrc), 64'd0);
    rstn = 1'b1;
    repeat (2) tick();

    // Single conditional taken record with idle lookup
    c = cyc;
    expect_upd(1'b1, 1'b1, 32'h100, 32'h200, c + 2);
    push(32'h100, 32'h200, 1'b1, 1'b1);
    chk("t1_count_after_push", 64'(q_count), 64'd1);
    chk("t1_no_stall", 64'(lookup_stall), 64'd0);
    tick();
    chk("t1_count_after_grant", 64'(q_count), 64'd0);
    drain();

    // Fill the queue under lookups, then a fifth push blocked while full
    c = cyc;
    lookup = 1'b1;
    for (int i = 0; i < 5; i++)
      expect_upd(1'b1, 1'(i % 2 == 0), 32'h1000 + 32'(i * 4), 32'h2000 + 32'(i), c + 5 + 2 * i);
    for (int i = 0; i < 4; i++)
      push(32'h1000 + 32'(i * 4), 32'h2000 + 32'(i), 1'b1, 1'(i % 2 == 0));
    chk("t2_full_ready", 64'(cmt_ready), 64'd0);
    chk("t2_full_count", 64'(q_count), 64'd4);
    lookup = 1'b0;
    pc = 32'h1010; tgt = 32'h2004; taken = 1'b1; is_cond = 1'b1; cmt_valid = 1'b1;
    tick();
    chk("t2_push_blocked_count", 64'(q_count), 64'd3);
    chk("t2_ready_after_pop", 64'(cmt_ready), 64'd1);
    tick();
    cmt_valid = 1'b0;
    chk("t2_late_push_count", 64'(q_count), 64'd4);
    drain();

    // Starvation: lookups held high, forced grant on the 8th queued cycle
    c = cyc;
    lookup = 1'b1;
    expect_upd(1'b0, 1'b1, 32'h300, 32'h304, c + 9);
    push(32'h300, 32'h304, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("t3_stall_k%0d", k), 64'(lookup_stall), 64'(k == 8));
      if (k < 8) tick();
    end
    chk("t3_count_at_force", 64'(q_count), 64'd1);
    tick();
    lookup = 1'b0;
    drain();

    // Uncond taken, cond not-taken, uncond not-taken (dropped), cond taken
    c = cyc;
    expect_upd(1'b1, 1'b0, 32'h400, 32'h480, c + 2);
    expect_upd(1'b0, 1'b1, 32'h410, 32'h490, c + 4);
    expect_upd(1'b1, 1'b1, 32'h430, 32'h4b0, c + 8);
    push(32'h400, 32'h480, 1'b1, 1'b0);
    push(32'h410, 32'h490, 1'b0, 1'b1);
    push(32'h420, 32'h4a0, 1'b0, 1'b0);
    push(32'h430, 32'h4b0, 1'b1, 1'b1);
    repeat (2) tick();
    chk("t4_drop_no_pulse", 64'({ubtb, upht, ghr, satcnt}), 64'd0);
    chk("t4_drop_src_held", 64'(jumpsrc), 64'h410);
    chk("t4_drop_dst_held", 64'(jumpdst), 64'h490);
    drain();

    // Flush with 3 queued, a grant pending and a concurrent push
    lookup = 1'b1;
    for (int i = 0; i < 3; i++) push(32'h500 + 32'(i), 32'h600, 1'b1, 1'b1);
    chk("t5_count_before_flush", 64'(q_count), 64'd3);
    lookup = 1'b0;
    flush = 1'b1;
    pc = 32'h5ff; tgt = 32'h6ff; taken = 1'b1; is_cond = 1'b1; cmt_valid = 1'b1;
    tick();
    flush = 1'b0;
    cmt_valid = 1'b0;
    chk("t5_flush_count", 64'(q_count), 64'd0);
    chk("t5_flush_no_pulse", 64'({ubtb, upht, ghr, satcnt}), 64'd0);
    repeat (3) tick();
    chk("t5_count_stays_zero", 64'(q_count), 64'd0);

    // A pulse registered before a flush still completes
    c = cyc;
    expect_upd(1'b1, 1'b0, 32'h700, 32'h780, c + 2);
    push(32'h700, 32'h780, 1'b1, 1'b0);
    tick();
    flush = 1'b1;
    chk("t6_pulse_in_flush", 64'(ubtb), 64'd1);
    tick();
    flush = 1'b0;
    drain();

    // Asynchronous reset mid-operation
    lookup = 1'b1;
    push(32'h800, 32'h880, 1'b1, 1'b1);
    push(32'h810, 32'h890, 1'b1, 1'b1);
    chk("t7_count_before_reset", 64'(q_count), 64'd2);
    #2 rstn = 1'b0;
    #1;
    chk("t7_async_count", 64'(q_count), 64'd0);
    chk("t7_async_ready", 64'(cmt_ready), 64'd1);
    chk("t7_async_jumpsrc", 64'(jumpsrc), 64'd0);
    lookup = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (5) tick();
    chk("t7_count_after_reset", 64'(q_count), 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
